// File: rtl/cram_async_ctrl_if.sv
// Core-side request/response handshake for the CellularRAM sequencer.
// The requester uses the master modport and the sequencer uses the slave modport.
interface cram_async_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [22:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  req_be;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/cram_async_ctrl.sv
// Asynchronous address/data-multiplexed CellularRAM access sequencer.
// Single-word accesses run through ADDR, DATA and REC phases timed by one shared down-counter.
//
//   state | meaning
//   IDLE  | ready for a request; chip deselected
//   ADDR  | address on DQ and A, adv_n low
//   DATA  | write drives wdata with we_n low, read opens oe_n
//   REC   | both chip enables high before the next access
module cram_async_ctrl #(
  parameter int T_ADV  = 2,
  parameter int T_DATA = 6,
  parameter int T_REC  = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  cram_async_ctrl_if.slave   req_if,
  output logic [5:0]         cram_a,
  output logic [15:0]        cram_dq_out,
  input  logic [15:0]        cram_dq_in,
  output logic               cram_adv_n,
  output logic               cram_ce0_n,
  output logic               cram_ce1_n,
  output logic               cram_oe_n,
  output logic               cram_we_n,
  output logic               cram_ub_n,
  output logic               cram_lb_n,
  output logic               cram_cre,
  output logic               cram_clk
);

  localparam int T_MAX1 = (T_ADV > T_DATA) ? T_ADV : T_DATA;
  localparam int T_MAX  = (T_MAX1 > T_REC) ? T_MAX1 : T_REC;
  localparam int CW     = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, REC} state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [22:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [1:0]  be_q, be_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [15:0] rsp_rdata_q, rsp_rdata_d;
  logic [5:0]  a_q, a_d;
  logic [15:0] dq_q, dq_d;
  logic        adv_n_q, adv_n_d;
  logic        ce0_n_q, ce0_n_d;
  logic        ce1_n_q, ce1_n_d;
  logic        oe_n_q, oe_n_d;
  logic        we_n_q, we_n_d;
  logic        ub_n_q, ub_n_d;
  logic        lb_n_q, lb_n_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;

    case (state_q)
      IDLE: begin
        if (req_if.req_valid) begin
          state_d = ADDR;
          cnt_d   = CW'(T_ADV - 1);
          write_d = req_if.req_write;
          addr_d  = req_if.req_addr;
          wdata_d = req_if.req_wdata;
          be_d    = req_if.req_be;
        end
      end
      ADDR: begin
        if (cnt_q == '0) begin
          state_d = DATA;
          cnt_d   = CW'(T_DATA - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          state_d = REC;
          cnt_d   = CW'(T_REC - 1);
          if (!write_q) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = cram_dq_in;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end
    endcase

    // Pins are decoded from the next state so they register glitch-free in step with it.
    a_d     = a_q;
    dq_d    = dq_q;
    adv_n_d = 1'b1;
    ce0_n_d = 1'b1;
    ce1_n_d = 1'b1;
    oe_n_d  = 1'b1;
    we_n_d  = 1'b1;
    ub_n_d  = 1'b1;
    lb_n_d  = 1'b1;

    case (state_d)
      ADDR: begin
        ce0_n_d = addr_d[22];
        ce1_n_d = ~addr_d[22];
        adv_n_d = 1'b0;
        a_d     = addr_d[21:16];
        dq_d    = addr_d[15:0];
      end
      DATA: begin
        ce0_n_d = addr_d[22];
        ce1_n_d = ~addr_d[22];
        a_d     = addr_d[21:16];
        if (write_d) begin
          we_n_d = 1'b0;
          dq_d   = wdata_d;
          ub_n_d = ~be_d[1];
          lb_n_d = ~be_d[0];
        end else begin
          oe_n_d = 1'b0;
          ub_n_d = 1'b0;
          lb_n_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      a_q         <= '0;
      dq_q        <= '0;
      adv_n_q     <= 1'b1;
      ce0_n_q     <= 1'b1;
      ce1_n_q     <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      ub_n_q      <= 1'b1;
      lb_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      a_q         <= a_d;
      dq_q        <= dq_d;
      adv_n_q     <= adv_n_d;
      ce0_n_q     <= ce0_n_d;
      ce1_n_q     <= ce1_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      ub_n_q      <= ub_n_d;
      lb_n_q      <= lb_n_d;
    end
  end

  assign req_if.req_ready = (state_q == IDLE);
  assign req_if.rsp_valid = rsp_valid_q;
  assign req_if.rsp_rdata = rsp_rdata_q;
  assign cram_a      = a_q;
  assign cram_dq_out = dq_q;
  assign cram_adv_n  = adv_n_q;
  assign cram_ce0_n  = ce0_n_q;
  assign cram_ce1_n  = ce1_n_q;
  assign cram_oe_n   = oe_n_q;
  assign cram_we_n   = we_n_q;
  assign cram_ub_n   = ub_n_q;
  assign cram_lb_n   = lb_n_q;
  assign cram_cre    = 1'b0;
  assign cram_clk    = 1'b0;

endmodule
